// File: rtl/iterative_shifter.sv
// Multi-cycle left/right shifter: STEP bits per clock, start/busy/done handshake, result held in data_out.
// Optional rotate-left on mode 11 when ITERATIVE_SHIFTER_ROTATE_EN is defined; otherwise mode 11 acts as SLL.
module iterative_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // One bit wider so STEP == WIDTH still compares correctly against remaining.
    localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W+1)'(STEP);

    state_t             state;
    logic [1:0]         mode_q;
    logic               sign_q;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   work_next;
    logic [SHAMT_W-1:0] remaining;
    logic [SHAMT_W-1:0] rem_next;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] w,
                                                input logic [1:0] m,
                                                input logic s);
        case (m)
            2'b01:   return {1'b0, w[WIDTH-1:1]};
            2'b10:   return {s, w[WIDTH-1:1]};
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
            2'b11:   return {w[WIDTH-2:0], w[WIDTH-1]};
`endif
            default: return {w[WIDTH-2:0], 1'b0};
        endcase
    endfunction

    // Apply min(STEP, remaining) single-bit steps in one cycle.
    always_comb begin
        work_next = work;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(remaining)) begin
                work_next = shift1(work_next, mode_q, sign_q);
            end
        end
        if ({1'b0, remaining} < STEP_L) begin
            rem_next = '0;
        end else begin
            rem_next = remaining - STEP_L[SHAMT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
            work      <= '0;
            remaining <= '0;
            mode_q    <= 2'b00;
            sign_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q    <= mode;
                        sign_q    <= data_in[WIDTH-1];
                        work      <= data_in;
                        remaining <= shamt;
                        if (shamt == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            data_out <= data_in;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    work      <= work_next;
                    remaining <= rem_next;
                    if (rem_next == '0) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        data_out <= work_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
